// File: rtl/writeback_buffer.sv
// rtl/writeback_buffer.sv - in-order result FIFO feeding the register file write port
// Merges ALU and load results, drains one per cycle, forwards pending values.
module writeback_buffer #(
  parameter int DEPTH     = 4,
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 5,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [TAG_WIDTH-1:0] alu_rd,
  input  logic [WIDTH-1:0]     alu_value,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [TAG_WIDTH-1:0] load_rd,
  input  logic [WIDTH-1:0]     load_value,
  output logic                 write_to_rd,
  output logic [TAG_WIDTH-1:0] rd,
  output logic [WIDTH-1:0]     rd_value,
  input  logic [TAG_WIDTH-1:0] rs1_query,
  output logic                 rs1_hit,
  output logic [WIDTH-1:0]     rs1_forward,
  input  logic [TAG_WIDTH-1:0] rs2_query,
  output logic                 rs2_hit,
  output logic [WIDTH-1:0]     rs2_forward,
  output logic [CNT_W-1:0]     occupancy
);

  logic [TAG_WIDTH-1:0] tag_q [DEPTH];
  logic [TAG_WIDTH-1:0] tag_d [DEPTH];
  logic [WIDTH-1:0]     val_q [DEPTH];
  logic [WIDTH-1:0]     val_d [DEPTH];
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic                 ready;
  logic                 load_enq;
  logic                 alu_enq;
  logic                 pop;
  logic [PTR_W-1:0]     alu_slot;
  logic [PTR_W-1:0]     slot [DEPTH];

  // Two free slots are required so both sources can always be taken together.
  always_comb begin
    ready       = (count_q <= CNT_W'(DEPTH - 2)) && !reset;
    alu_ready   = ready;
    load_ready  = ready;
    load_enq    = load_valid && ready && (load_rd != '0);
    alu_enq     = alu_valid && ready && (alu_rd != '0);
    pop         = (count_q != '0) && !reset;
    write_to_rd = pop;
    rd          = (count_q != '0) ? tag_q[head_q] : '0;
    rd_value    = (count_q != '0) ? val_q[head_q] : '0;
    occupancy   = count_q;
  end

  // Load is the older result, so it takes the tail slot ahead of the ALU entry.
  always_comb begin
    tag_d    = tag_q;
    val_d    = val_q;
    alu_slot = tail_q + PTR_W'(load_enq);
    if (load_enq) begin
      tag_d[tail_q] = load_rd;
      val_d[tail_q] = load_value;
    end
    if (alu_enq) begin
      tag_d[alu_slot] = alu_rd;
      val_d[alu_slot] = alu_value;
    end
    tail_d  = tail_q + PTR_W'(load_enq) + PTR_W'(alu_enq);
    head_d  = head_q + PTR_W'(pop);
    count_d = count_q + CNT_W'(load_enq) + CNT_W'(alu_enq) - CNT_W'(pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
    tag_q <= tag_d;
    val_q <= val_d;
  end

  // Walk oldest to newest so a later match overwrites an earlier one.
  always_comb begin
    rs1_hit     = 1'b0;
    rs1_forward = '0;
    rs2_hit     = 1'b0;
    rs2_forward = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot[i] = head_q + PTR_W'(i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_q) begin
        if ((rs1_query != '0) && (tag_q[slot[i]] == rs1_query)) begin
          rs1_hit     = 1'b1;
          rs1_forward = val_q[slot[i]];
        end
        if ((rs2_query != '0) && (tag_q[slot[i]] == rs2_query)) begin
          rs2_hit     = 1'b1;
          rs2_forward = val_q[slot[i]];
        end
      end
    end
    if (reset) begin
      rs1_hit     = 1'b0;
      rs1_forward = '0;
      rs2_hit     = 1'b0;
      rs2_forward = '0;
    end
  end

endmodule

// File: tb/tb_writeback_buffer.sv
// tb/tb_writeback_buffer.sv - scoreboard bench for writeback_buffer
module tb_writeback_buffer;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int TW    = 5;

  logic             clock;
  logic             reset;
  logic             alu_valid, alu_ready;
  logic [TW-1:0]    alu_rd;
  logic [WIDTH-1:0] alu_value;
  logic             load_valid, load_ready;
  logic [TW-1:0]    load_rd;
  logic [WIDTH-1:0] load_value;
  logic             write_to_rd;
  logic [TW-1:0]    rd;
  logic [WIDTH-1:0] rd_value;
  logic [TW-1:0]    rs1_query, rs2_query;
  logic             rs1_hit, rs2_hit;
  logic [WIDTH-1:0] rs1_forward, rs2_forward;
  logic [2:0]       occupancy;

  writeback_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .TAG_WIDTH(TW)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_value(alu_value),
    .load_valid(load_valid), .load_ready(load_ready), .load_rd(load_rd), .load_value(load_value),
    .write_to_rd(write_to_rd), .rd(rd), .rd_value(rd_value),
    .rs1_query(rs1_query), .rs1_hit(rs1_hit), .rs1_forward(rs1_forward),
    .rs2_query(rs2_query), .rs2_hit(rs2_hit), .rs2_forward(rs2_forward),
    .occupancy(occupancy)
  );

  typedef struct packed {
    logic [TW-1:0]    tag;
    logic [WIDTH-1:0] val;
  } ent_t;

  ent_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   occ_m = 0;
  int   occ_next = 0;
  bit   accepted;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every register file write must match the oldest expected entry.
  always @(negedge clock) begin
    if (reset) begin
      chk("write_in_reset", write_to_rd, 0);
    end else if (write_to_rd) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got rd=%0d value=0x%0h expected no write", rd, rd_value);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("rd", rd, e.tag);
        chk("rd_value", rd_value, e.val);
      end
    end
  end

  task automatic drive(input bit lv, input int lrd, input int lval,
                       input bit av, input int ard, input int aval);
    load_valid = lv;
    load_rd    = TW'(lrd);
    load_value = WIDTH'(lval);
    alu_valid  = av;
    alu_rd     = TW'(ard);
    alu_value  = WIDTH'(aval);
  endtask

  task automatic sample();
    int enq;
    @(negedge clock);
    accepted = 0;
    enq = 0;
    if (reset) begin
      chk("alu_ready_in_reset", alu_ready, 0);
      chk("load_ready_in_reset", load_ready, 0);
      chk("rs1_hit_in_reset", rs1_hit, 0);
      chk("rs2_hit_in_reset", rs2_hit, 0);
      occ_next = 0;
    end else begin
      chk("occupancy", occupancy, occ_m);
      chk("alu_ready", alu_ready, (occ_m <= DEPTH - 2));
      chk("load_ready", load_ready, (occ_m <= DEPTH - 2));
      chk("write_to_rd", write_to_rd, (occ_m != 0));
      if (occ_m == 0) begin
        chk("rd_empty", rd, 0);
        chk("rd_value_empty", rd_value, 0);
      end
      if (occ_m <= DEPTH - 2) begin
        accepted = 1;
        if (load_valid && load_rd != 0) begin
          exp_q.push_back({load_rd, load_value});
          enq++;
        end
        if (alu_valid && alu_rd != 0) begin
          exp_q.push_back({alu_rd, alu_value});
          enq++;
        end
      end
      occ_next = occ_m + enq - ((occ_m != 0) ? 1 : 0);
    end
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
    if (reset) begin
      occ_m = 0;
      exp_q.delete();
    end else begin
      occ_m = occ_next;
    end
  endtask

  task automatic step();
    sample();
    adv();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int p;
    int cyc;
    reset = 1'b1;
    rs1_query = '0;
    rs2_query = '0;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clock);
    #1;
    step();
    step();
    reset = 1'b0;
    rs1_query = TW'(3);
    sample();
    chk("rs1_hit_after_reset", rs1_hit, 0);
    chk("rs1_forward_after_reset", rs1_forward, 0);
    adv();

    // Single ALU result, one-cycle latency to the write port.
    drive(0, 0, 0, 1, 3, 'h10);
    step();
    drive(0, 0, 0, 0, 0, 0);
    step();
    step();

    // Same tag from both sources: load is older, ALU value is forwarded.
    drive(1, 5, 9, 1, 5, 7);
    step();
    drive(0, 0, 0, 0, 0, 0);
    rs1_query = TW'(5);
    sample();
    chk("fwd_hit_c1", rs1_hit, 1);
    chk("fwd_val_c1", rs1_forward, 7);
    adv();
    sample();
    chk("fwd_hit_c2", rs1_hit, 1);
    chk("fwd_val_c2", rs1_forward, 7);
    adv();
    sample();
    chk("fwd_hit_c3", rs1_hit, 0);
    chk("fwd_val_c3", rs1_forward, 0);
    adv();

    // Both sources streaming; each pair held until accepted.
    p = 0;
    cyc = 0;
    rs2_query = '0;
    while (p < 5 && cyc < 30) begin
      drive(1, 10 + p, 'h100 + p, 1, 20 + p, 'h200 + p);
      sample();
      chk("rs2_zero_query", rs2_hit, 0);
      if (accepted) p++;
      adv();
      cyc++;
    end
    chk("stream_pairs_accepted", p, 5);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step();

    // x0 results complete their handshake but never reach the write port.
    drive(1, 0, 'h55, 1, 0, 'hFF);
    rs2_query = '0;
    sample();
    chk("x0_rs2_hit", rs2_hit, 0);
    adv();
    drive(0, 0, 0, 0, 0, 0);
    step();
    step();

    // Reset with three entries buffered discards them.
    drive(1, 1, 'h11, 1, 2, 'h22);
    step();
    drive(1, 3, 'h33, 1, 4, 'h44);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("occ_before_reset", occ_m, 3);
    rs1_query = TW'(4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    sample();
    chk("rs1_hit_post_flush", rs1_hit, 0);
    adv();
    drive(0, 0, 0, 1, 7, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    step();
    step();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/writeback_buffer.md
Name: writeback_buffer

Overview:
- Producer side of the register file write port (write_to_rd / rd / rd_value).
- Collects completed results from two pipeline sources, the ALU result path and the load return path, into a small in-order FIFO.
- Drains that FIFO into the single register file write port at one write per cycle.
- Provides operand forwarding from entries that are buffered but not yet written, so decode never reads stale registers.

Parameters:
- DEPTH, 4, number of buffered results; power of two, minimum 4.
- WIDTH, 32, width of a word.
- TAG_WIDTH, 5, width of a register tag.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- alu_valid  input  1  ALU result offered this cycle.
- alu_ready  output  1  buffer can accept an ALU result this cycle.
- alu_rd  input  TAG_WIDTH  destination tag of the ALU result.
- alu_value  input  WIDTH  ALU result value.
- load_valid  input  1  load result offered this cycle.
- load_ready  output  1  buffer can accept a load result this cycle.
- load_rd  input  TAG_WIDTH  destination tag of the load result.
- load_value  input  WIDTH  load result value.
- write_to_rd  output  1  register file write enable.
- rd  output  TAG_WIDTH  register file write tag.
- rd_value  output  WIDTH  register file write data.
- rs1_query  input  TAG_WIDTH  forwarding lookup tag, port 1.
- rs1_hit  output  1  a buffered entry matches rs1_query.
- rs1_forward  output  WIDTH  value of the newest matching entry for rs1_query.
- rs2_query  input  TAG_WIDTH  forwarding lookup tag, port 2.
- rs2_hit  output  1  a buffered entry matches rs2_query.
- rs2_forward  output  WIDTH  value of the newest matching entry for rs2_query.
- occupancy  output  clog2(DEPTH)+1  number of buffered entries.

Behaviour:
- Storage: circular FIFO of DEPTH entries of {tag, value}, with head and tail pointers and a count.
- Reset (synchronous, active-high):
  - At the edge: count=0, head=0, tail=0.
  - While reset is high: alu_ready=0, load_ready=0, write_to_rd=0, rs1_hit=0, rs2_hit=0, regardless of stored state.
  - After release: occupancy=0, rd=0, rd_value=0, forward outputs=0.
- Ready:
  - alu_ready = load_ready = (count <= DEPTH-2) and not reset.
  - Both ready signals are always equal, so two results can always be accepted in the same cycle.
- Accept: a source's result is accepted at a rising edge when its valid and ready are both high.
- x0 results:
  - Accepted results with tag 0 are consumed (the handshake completes) but not enqueued.
  - No x0 write ever reaches the register file.
- Enqueue order: when both sources are accepted in the same cycle, the load entry is enqueued first, as the older result, then the ALU entry.
- Drain:
  - write_to_rd = (count != 0) and not reset; rd and rd_value equal the head entry.
  - Outputs are combinational from state; at each rising edge where write_to_rd=1, the head is popped.
  - rd and rd_value read 0 when count=0.
- Latency: a result accepted at edge k into an empty buffer is driven on the write port during cycle k+1 and written by the register file at edge k+1.
- Count update:
  - count_next = count + enqueued(0..2) - popped(0..1).
  - Pointers wrap modulo DEPTH.
  - Overflow is impossible by the ready rule.
- Simultaneous pop and enqueue into an empty buffer: pop applies only to pre-edge contents, so there is no same-edge bypass of an incoming result onto the write port.
- Forwarding:
  - Combinational; a query tag of 0 never hits.
  - The search covers all valid entries including the head.
  - Priority is newest first, with the tail-side entry winning.
  - On a miss, the forward output is 0.
- Reset mid-operation: all buffered entries are discarded and no further writes are issued for them. Flushing committed results is the owner's responsibility; reset is the only clear.

Test Plan:
- Assert reset 2 cycles, then release -> write_to_rd=0, alu_ready=load_ready=1, occupancy=0, rs1_hit=0.
- ALU rd=3, value=0x10, one cycle -> next cycle write_to_rd=1, rd=3, rd_value=0x10; cycle after that write_to_rd=0, occupancy=0.
- Same-cycle load rd=5 value=9 and ALU rd=5 value=7 -> write port shows 5/9, then 5/7; rs1_query=5 during the first drain cycle gives rs1_hit=1, rs1_forward=7; the third cycle gives rs1_hit=0.
- Both sources valid every cycle:
  - occupancy goes 2, 3, and ready drops at occupancy 3.
  - Sources stall, occupancy drains to 2, ready rises.
  - Tags drain strictly in load-before-ALU, cycle order; no entry is lost or duplicated.
- ALU rd=0 value=0xFF and load rd=0 -> both handshakes complete, write_to_rd never asserts, occupancy stays 0, rs2_query=0 gives rs2_hit=0.
- Three entries buffered, assert reset one cycle -> write_to_rd=0 during and after reset, occupancy=0; the next accepted result rd=7 value=1 drains normally.
